// File: rtl/tt_sweep_checker_if.sv
// ----------------------------------------------------------------------------
// tt_sweep_checker_if
//   Bundles the control and result signals of tt_sweep_checker.
//   master : the side that starts sweeps and closes the loop through the
//            block under test (drives start and obs, reads results)
//   slave  : the checker itself (reads start and obs, drives stim and results)
//
//   start           sweep request, sampled on the clk rising edge
//   obs             outputs of the block under test
//   stim            input vector applied to the block under test
//   busy            sweep in progress
//   done            sweep finished, results valid
//   pass            done with zero mismatches
//   err_count       mismatching vectors, saturating at 2**NUM_IN
//   first_fail_idx  index of the first mismatching vector
//   first_fail_obs  obs captured at the first mismatch
// ----------------------------------------------------------------------------
interface tt_sweep_checker_if #(
  parameter int NUM_IN  = 3,
  parameter int NUM_OUT = 5
);
  logic                start;
  logic [NUM_OUT-1:0]  obs;
  logic [NUM_IN-1:0]   stim;
  logic                busy;
  logic                done;
  logic                pass;
  logic [NUM_IN:0]     err_count;
  logic [NUM_IN-1:0]   first_fail_idx;
  logic [NUM_OUT-1:0]  first_fail_obs;

  modport master (
    output start, obs,
    input  stim, busy, done, pass, err_count, first_fail_idx, first_fail_obs
  );

  modport slave (
    input  start, obs,
    output stim, busy, done, pass, err_count, first_fail_idx, first_fail_obs
  );
endinterface

// File: rtl/tt_sweep_checker.sv
// ----------------------------------------------------------------------------
// tt_sweep_checker
//   Exhaustive truth-table checker for a small combinational block. On start
//   it walks stim through 0 .. 2**NUM_IN-1, holds each vector for SETTLE
//   cycles, samples obs for one cycle and compares it with the matching
//   NUM_OUT-bit slice of EXPECTED. Mismatches are counted (saturating) and
//   the first failing vector and its observed value are latched.
//
//   Ports:
//     clk    system clock, rising edge
//     rst_n  asynchronous active-low reset
//     bus    tt_sweep_checker_if.slave (start, obs in; stim and results out)
//
//   Build option:
//     TT_STOP_ON_FAIL_EN  when defined, the first mismatch ends the sweep with
//                         stim held at the failing vector.
// ----------------------------------------------------------------------------
module tt_sweep_checker #(
  parameter int                            NUM_IN   = 3,
  parameter int                            NUM_OUT  = 5,
  parameter int                            SETTLE   = 2,
  parameter logic [(NUM_OUT<<NUM_IN)-1:0]  EXPECTED = '0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  tt_sweep_checker_if.slave    bus
);

  localparam int               NVEC        = 1 << NUM_IN;
  localparam logic [NUM_IN:0]  ERR_MAX     = (NUM_IN+1)'(NVEC);
  localparam logic [NUM_IN-1:0] LAST_VEC   = '1;
  localparam logic [3:0]       SETTLE_LAST = 4'(SETTLE - 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DRIVE  = 2'd1;
  localparam logic [1:0] ST_SAMPLE = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  function automatic logic [NUM_IN:0] sat_inc(input logic [NUM_IN:0] v);
    return (v >= ERR_MAX) ? v : v + 1'b1;
  endfunction

  logic [1:0]          state;
  logic [3:0]          settle_cnt;
  logic                fail_seen;

  logic [NUM_OUT-1:0]  exp_obs;
  logic                mismatch;
  logic [NUM_IN:0]     err_next;
  logic                sweep_end;

  // Comparison against the golden slice for the vector currently applied.
  always_comb begin
    exp_obs  = EXPECTED[int'(bus.stim)*NUM_OUT +: NUM_OUT];
    mismatch = (bus.obs != exp_obs);
    err_next = mismatch ? sat_inc(bus.err_count) : bus.err_count;
`ifdef TT_STOP_ON_FAIL_EN
    sweep_end = mismatch || (bus.stim == LAST_VEC);
`else
    sweep_end = (bus.stim == LAST_VEC);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state              <= ST_IDLE;
      settle_cnt         <= '0;
      fail_seen          <= 1'b0;
      bus.stim           <= '0;
      bus.busy           <= 1'b0;
      bus.done           <= 1'b0;
      bus.pass           <= 1'b0;
      bus.err_count      <= '0;
      bus.first_fail_idx <= '0;
      bus.first_fail_obs <= '0;
    end else begin
      case (state)
        // Idle and done behave identically on start; done simply keeps the
        // previous sweep's results visible until then.
        ST_IDLE, ST_DONE: begin
          if (bus.start) begin
            state              <= ST_DRIVE;
            settle_cnt         <= '0;
            fail_seen          <= 1'b0;
            bus.stim           <= '0;
            bus.busy           <= 1'b1;
            bus.done           <= 1'b0;
            bus.pass           <= 1'b0;
            bus.err_count      <= '0;
            bus.first_fail_idx <= '0;
            bus.first_fail_obs <= '0;
          end
        end

        // Hold the vector for exactly SETTLE cycles.
        ST_DRIVE: begin
          settle_cnt <= settle_cnt + 1'b1;
          if (settle_cnt == SETTLE_LAST) begin
            state <= ST_SAMPLE;
          end
        end

        ST_SAMPLE: begin
          bus.err_count <= err_next;
          if (mismatch && !fail_seen) begin
            fail_seen          <= 1'b1;
            bus.first_fail_idx <= bus.stim;
            bus.first_fail_obs <= bus.obs;
          end
          if (sweep_end) begin
            // pass uses the count including this vector's result.
            state    <= ST_DONE;
            bus.busy <= 1'b0;
            bus.done <= 1'b1;
            bus.pass <= (err_next == '0);
          end else begin
            state      <= ST_DRIVE;
            settle_cnt <= '0;
            bus.stim   <= bus.stim + 1'b1;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
